// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: immediate format selector and default datapath width.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4,
      IMM_Z = 3'd5
   } immediate_type_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: gathers the immediate bits of one instruction
// word and sign-extends them to XLEN; encodings 6 and 7 yield zero flagged illegal.
module imm_decode
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  immediate_type_e        imm_source,
   input  logic [31:0]            imm_instruction,
   output logic signed [XLEN-1:0] imm_value,
   output logic                   imm_illegal
);

   logic signed [31:0] imm_word;

   always_comb begin
      imm_word    = '0;
      imm_illegal = 1'b0;
      case (imm_source)
         IMM_I: imm_word = {{20{imm_instruction[31]}}, imm_instruction[31:20]};
         IMM_S: imm_word = {{20{imm_instruction[31]}}, imm_instruction[31:25],
                            imm_instruction[11:7]};
         IMM_B: imm_word = {{19{imm_instruction[31]}}, imm_instruction[31], imm_instruction[7],
                            imm_instruction[30:25], imm_instruction[11:8], 1'b0};
         IMM_U: imm_word = {imm_instruction[31:12], 12'b0};
         IMM_J: imm_word = {{11{imm_instruction[31]}}, imm_instruction[31],
                            imm_instruction[19:12], imm_instruction[20],
                            imm_instruction[30:21], 1'b0};
         IMM_Z: imm_word = {27'b0, imm_instruction[19:15]};
         default: imm_illegal = 1'b1;
      endcase
   end

   // Every format fits in 32 signed bits (Z is non-negative), so one signed widening
   // covers both sign- and zero-extension, including U-type on a 64-bit datapath.
   assign imm_value = XLEN'(imm_word);

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a DEPTH-entry valid/ready output FIFO; the decode result
// is written straight into the buffer, giving one cycle from accept to head.
module imm_extend_pipe
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  immediate_type_e        imm_source,
   input  logic [31:0]            imm_instruction,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        imm_extended,
   output logic                   imm_illegal,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   logic signed [XLEN-1:0] dec_value_p0;
   logic                   dec_illegal_p0;

   logic signed [XLEN-1:0] data_mem_p1    [DEPTH];
   logic                   illegal_mem_p1 [DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [OCC_W-1:0]       occ_q;
   logic                   push;
   logic                   pop;

   // Stage p0: combinational decode of the incoming request
   imm_decode #(.XLEN(XLEN)) u_decode (
      .imm_source      (imm_source),
      .imm_instruction (imm_instruction),
      .imm_value       (dec_value_p0),
      .imm_illegal     (dec_illegal_p0)
   );

   assign in_ready  = (occ_q != FULL_OCC);
   assign out_valid = (occ_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign occupancy = occ_q;

   // Stage p1: buffer control; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // A write landing during reset is harmless: the pointers restart and it is never read.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_p1[wr_ptr]    <= dec_value_p0;
         illegal_mem_p1[wr_ptr] <= dec_illegal_p0;
      end
   end

   assign imm_extended = out_valid ? data_mem_p1[rd_ptr]    : '0;
   assign imm_illegal  = out_valid ? illegal_mem_p1[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: 32- and 64-bit instances share stimulus and are checked
// every cycle against a queue model with an arithmetic immediate reference.
module tb_imm_extend_pipe;
   import riscv_pkg::*;

   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            out_ready;
   immediate_type_e imm_source;
   logic [31:0]     imm_instruction;

   logic        in_ready32, out_valid32, illegal32;
   logic [31:0] ext32;
   logic [1:0]  occ32;
   logic        in_ready64, out_valid64, illegal64;
   logic [63:0] ext64;
   logic [1:0]  occ64;

   int n_tests = 0;
   int n_fail  = 0;

   logic [64:0] model_q[$];

   always #5 clk = ~clk;

   imm_extend_pipe #(.XLEN(32), .DEPTH(DEPTH)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .imm_source(imm_source), .imm_instruction(imm_instruction),
      .out_valid(out_valid32), .out_ready(out_ready), .imm_extended(ext32),
      .imm_illegal(illegal32), .occupancy(occ32)
   );

   imm_extend_pipe #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
      .imm_source(imm_source), .imm_instruction(imm_instruction),
      .out_valid(out_valid64), .out_ready(out_ready), .imm_extended(ext64),
      .imm_illegal(illegal64), .occupancy(occ64)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference immediate from shifts and sums of the raw word; {illegal, value64}
   function automatic logic [64:0] ref_imm(input logic [2:0] src, input logic [31:0] inst);
      int     si;
      longint s;
      longint v;
      si = int'(inst);
      s  = si;
      v  = 0;
      case (src)
         3'd0: v = s >>> 20;
         3'd1: v = ((s >>> 25) <<< 5) + longint'(inst[11:7]);
         3'd2: v = ((s >>> 31) <<< 12) + (longint'(inst[7]) << 11)
                 + (longint'(inst[30:25]) << 5) + (longint'(inst[11:8]) << 1);
         3'd3: v = s & -64'sd4096;
         3'd4: v = ((s >>> 31) <<< 20) + (longint'(inst[19:12]) << 12)
                 + (longint'(inst[20]) << 11) + (longint'(inst[30:21]) << 1);
         3'd5: v = longint'(inst[19:15]);
         default: return {1'b1, 64'd0};
      endcase
      return {1'b0, 64'(v)};
   endfunction

   task automatic drive(input logic v, input logic [2:0] src, input logic [31:0] inst,
                        input logic ordy);
      in_valid        = v;
      imm_source      = immediate_type_e'(src);
      imm_instruction = inst;
      out_ready       = ordy;
   endtask

   // One clock: advance the model with the pre-edge inputs, then compare both DUTs.
   task automatic step();
      logic        push_m, pop_m;
      logic [64:0] head;
      push_m = in_valid && (model_q.size() < DEPTH);
      pop_m  = out_ready && (model_q.size() != 0);
      if (rst) model_q.delete();
      else begin
         if (pop_m)  void'(model_q.pop_front());
         if (push_m) model_q.push_back(ref_imm(imm_source, imm_instruction));
      end
      @(posedge clk);
      #1;
      head = (model_q.size() != 0) ? model_q[0] : '0;
      check("occ32",      64'(occ32),       64'(model_q.size()));
      check("occ64",      64'(occ64),       64'(model_q.size()));
      check("in_ready32", 64'(in_ready32),  64'(model_q.size() < DEPTH));
      check("in_ready64", 64'(in_ready64),  64'(model_q.size() < DEPTH));
      check("out_valid32",64'(out_valid32), 64'(model_q.size() != 0));
      check("out_valid64",64'(out_valid64), 64'(model_q.size() != 0));
      check("ext32",      64'(ext32),       64'(head[31:0]));
      check("ext64",      ext64,            head[63:0]);
      check("ill32",      64'(illegal32),   64'(head[64]));
      check("ill64",      64'(illegal64),   64'(head[64]));
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      step();
      step();
      check("reset_occ", 64'(occ32), 64'd0);
      check("reset_rdy", 64'(in_ready32), 64'd1);
      rst = 1'b0;

      // I-type all-ones immediate, then B, Z, U on the following cycles
      drive(1'b1, 3'd0, 32'hFFF00093, 1'b1);
      step();
      check("i_ext32", 64'(ext32), 64'hFFFF_FFFF);
      check("i_valid", 64'(out_valid32), 64'd1);
      drive(1'b1, 3'd2, 32'hFE000EE3, 1'b1);
      step();
      check("b_ext32", 64'(ext32), 64'hFFFF_FFFC);
      drive(1'b1, 3'd5, 32'h000F5073, 1'b1);
      step();
      check("z_ext32", 64'(ext32), 64'h0000_001E);
      drive(1'b1, 3'd3, 32'h800002B7, 1'b1);
      step();
      check("u_ext64", ext64, 64'hFFFF_FFFF_8000_0000);
      drive(1'b0, 3'd0, 32'h0, 1'b1);
      step();
      check("drained", 64'(out_valid32), 64'd0);

      // Back-pressure: three pushes into a two-entry buffer
      drive(1'b1, 3'd0, 32'h00100093, 1'b0);
      step();
      drive(1'b1, 3'd1, 32'hFE112E23, 1'b0);
      step();
      drive(1'b1, 3'd4, 32'h8000006F, 1'b0);
      step();
      check("bp_occ", 64'(occ32), 64'd2);
      check("bp_rdy", 64'(in_ready32), 64'd0);
      check("bp_head", 64'(ext32), 64'd1);
      drive(1'b1, 3'd4, 32'h8000006F, 1'b1);
      step();
      check("bp_pop1", 64'(occ32), 64'd1);
      step();
      drive(1'b0, 3'd0, 32'h0, 1'b1);
      step();
      step();

      // Illegal source, then continuous push+pop at steady occupancy one
      drive(1'b1, 3'd7, 32'hFFFFFFFF, 1'b1);
      step();
      check("ill_ext", 64'(ext32), 64'd0);
      check("ill_flag", 64'(illegal32), 64'd1);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'($urandom_range(0, 7)), $urandom, 1'b1);
         step();
         check("steady_occ", 64'(occ32), 64'd1);
      end

      // Reset with a full buffer, then a fresh push
      drive(1'b1, 3'd0, 32'h7FF00093, 1'b0);
      step();
      step();
      check("pre_rst_occ", 64'(occ32), 64'd2);
      rst = 1'b1;
      drive(1'b1, 3'd2, 32'h00000463, 1'b0);
      step();
      rst = 1'b0;
      check("rst_occ", 64'(occ32), 64'd0);
      check("rst_valid", 64'(out_valid64), 64'd0);
      check("rst_rdy", 64'(in_ready64), 64'd1);
      drive(1'b1, 3'd0, 32'h80000093, 1'b1);
      step();
      check("fresh_ext64", ext64, 64'hFFFF_FFFF_FFFF_F800);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 2) != 0));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; power of two, 2..8.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted this cycle when high with in_valid.
REQ-007 SHALL have port imm_source, input, immediate_type_e (3 bits), immediate format select.
REQ-008 SHALL have port imm_instruction, input, 32, raw instruction word.
REQ-009 SHALL have port out_valid, output, 1, buffer head holds a result.
REQ-010 SHALL have port out_ready, input, 1, consumer takes head when high with out_valid.
REQ-011 SHALL have port imm_extended, output, XLEN, head result.
REQ-012 SHALL have port imm_illegal, output, 1, head entry came from an unsupported imm_source.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH)+1, buffered entry count.

Function
REQ-014 SHALL decode: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = sext({inst[31:12],12'b0}); J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); Z = zext(inst[19:15]).
REQ-015 SHALL sign-extend to full XLEN, including U-type when XLEN=64.
REQ-016 SHALL, for encodings 6 and 7, store result 0 with imm_illegal=1; legal types store imm_illegal=0.
REQ-017 SHALL accept (push) when in_valid && in_ready; in_ready = (occupancy < DEPTH), independent of out_ready.
REQ-018 SHALL pop when out_valid && out_ready; out_valid = (occupancy != 0).
REQ-019 SHALL give latency 1: an accept into an empty buffer raises out_valid on the following cycle with that result at head.
REQ-020 SHALL preserve strict FIFO order; read/write pointers wrap modulo DEPTH.
REQ-021 SHALL handle simultaneous push and pop with occupancy unchanged and both operations applied.
REQ-022 SHALL hold imm_extended/imm_illegal stable while out_valid && !out_ready.
REQ-023 SHALL ignore in_valid when in_ready is low (no drop, no overwrite); pop from empty is a no-op.
REQ-024 SHALL drive imm_extended=0, imm_illegal=0 whenever out_valid is low.

Reset
REQ-025 SHALL, with rst high at an edge, clear pointers and occupancy to 0; out_valid=0, imm_extended=0, imm_illegal=0, in_ready=1 next cycle.
REQ-026 SHALL discard all buffered entries on reset mid-operation; a push coinciding with reset is dropped.

Structure
REQ-027 SHALL define immediate_type_e in riscv_pkg as 3-bit: IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_Z=5; XLEN default constant also in riscv_pkg.
REQ-028 SHALL instantiate the combinational decoder as sub-module imm_decode (XLEN-parametrised); buffer and control live in imm_extend_pipe.

Verification
REQ-029 SHALL cover XLEN=32, IMM_I, 0xFFF00093, out_ready=1 -> one cycle later out_valid=1, imm_extended=0xFFFFFFFF, imm_illegal=0.
REQ-030 SHALL cover IMM_B 0xFE000EE3 -> 0xFFFFFFFC; IMM_Z 0x000F5073 -> 0x0000001E.
REQ-031 SHALL cover XLEN=64, IMM_U 0x800002B7 -> 0xFFFFFFFF80000000.
REQ-032 SHALL cover DEPTH=2, out_ready=0, three back-to-back pushes -> first two accepted, in_ready=0 and third held, occupancy=2; raise out_ready -> results emerge in order, third accepted after first pop.
REQ-033 SHALL cover imm_source=7 -> imm_extended=0, imm_illegal=1; then continuous push+pop with occupancy=1 steady.
REQ-034 SHALL cover rst asserted with occupancy=2 -> next cycle occupancy=0, out_valid=0, in_ready=1; later push returns correct fresh result.
